// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - knight-tour command scheduler feeding RemoteComm
// Move-code FIFO plus the FSM that turns each move into CAL/X/Y commands with A5 acks.

module tour_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         push, pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push    = wr_i & ~full_o;
  assign pop     = rd_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module tour_cmd_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int RESP_TIMEOUT = 2000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mv_wr_i,
  input  logic [2:0]  mv_in_i,
  input  logic        go_i,
  output logic        fifo_full_o,
  output logic [15:0] cmd_o,
  output logic        snd_cmd_o,
  input  logic        cmd_snt_i,
  input  logic        resp_rdy_i,
  input  logic [7:0]  resp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [4:0]  legs_ok_o
);
  localparam int         TW       = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [3:0]  OP_MOVE  = 4'h4;
  localparam logic [3:0]  OP_FANF  = 4'h5;
  localparam logic [7:0]  HDG_N    = 8'h00;
  localparam logic [7:0]  HDG_W    = 8'h3F;
  localparam logic [7:0]  HDG_S    = 8'h7F;
  localparam logic [7:0]  HDG_E    = 8'hBF;
  localparam logic [7:0]  ACK      = 8'hA5;
  localparam logic [1:0]  ERR_RESP = 2'b01;
  localparam logic [1:0]  ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CAL, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_LOAD, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {LEG_CAL, LEG_X, LEG_Y} leg_e;

  state_e        state_q, state_d;
  leg_e          leg_q, leg_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          snd_q, snd_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    code_q, code_d;
  logic [4:0]    legs_q, legs_d;
  logic [1:0]    errc_q, errc_d;
  logic          pop;
  logic [2:0]    head;
  logic          empty;

  tour_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (mv_wr_i),
    .wdata_i (mv_in_i),
    .rd_i    (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (fifo_full_o)
  );

  // Codes 0-3 move east; |dx|==1 exactly when code[1]==code[0], and then |dy|==2.
  function automatic logic [15:0] x_leg(input logic [2:0] code);
    logic [7:0] hdg;
    logic [3:0] sq;
    hdg = code[2] ? HDG_W : HDG_E;
    sq  = (code[1] ~^ code[0]) ? 4'd1 : 4'd2;
    return {OP_MOVE, hdg, sq};
  endfunction

  // North for codes 0,1,6,7, i.e. when code[2]==code[1].
  function automatic logic [15:0] y_leg(input logic [2:0] code, input logic last);
    logic [7:0] hdg;
    logic [3:0] sq;
    hdg = (code[2] ~^ code[1]) ? HDG_N : HDG_S;
    sq  = (code[1] ~^ code[0]) ? 4'd2 : 4'd1;
    return {(last ? OP_FANF : OP_MOVE), hdg, sq};
  endfunction

  always_comb begin
    state_d = state_q;
    leg_d   = leg_q;
    cmd_d   = cmd_q;
    timer_d = timer_q;
    code_d  = code_q;
    legs_d  = legs_q;
    errc_d  = errc_q;
    pop     = 1'b0;
    snd_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go_i) begin
          if (state_q != S_IDLE) begin
            legs_d  = '0;
            errc_d  = '0;
            state_d = S_IDLE;
          end
          if (!empty) begin
            state_d = S_CAL;
            cmd_d   = CAL_GYRO;
            leg_d   = LEG_CAL;
          end
        end
      end
      S_CAL, S_SEND: state_d = S_WAIT_SNT;
      S_WAIT_SNT: begin
        if (cmd_snt_i) begin
          timer_d = '0;
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        timer_d = timer_q + 1'b1;
        if (resp_rdy_i) begin
          if (resp_i == ACK) begin
            if (leg_q != LEG_CAL && legs_q != 5'd31) legs_d = legs_q + 5'd1;
            if (leg_q == LEG_X) begin
              cmd_d   = y_leg(code_q, empty);
              leg_d   = LEG_Y;
              state_d = S_SEND;
            end else begin
              state_d = empty ? S_DONE : S_LOAD;
            end
          end else begin
            errc_d  = ERR_RESP;
            state_d = S_ERR;
          end
        end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
          errc_d  = ERR_TMO;
          state_d = S_ERR;
        end
      end
      S_LOAD: begin
        pop     = 1'b1;
        code_d  = head;
        cmd_d   = x_leg(head);
        leg_d   = LEG_X;
        state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered pulse: high for exactly the one cycle spent in CAL/SEND.
    snd_d = (state_d == S_CAL) || (state_d == S_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      leg_q   <= LEG_CAL;
      cmd_q   <= '0;
      snd_q   <= 1'b0;
      timer_q <= '0;
      code_q  <= '0;
      legs_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      leg_q   <= leg_d;
      cmd_q   <= cmd_d;
      snd_q   <= snd_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      legs_q  <= legs_d;
      errc_q  <= errc_d;
    end
  end

  assign cmd_o      = cmd_q;
  assign snd_cmd_o  = snd_q;
  assign busy_o     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);
  assign err_code_o = errc_q;
  assign legs_ok_o  = legs_q;
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb/tb_tour_cmd_sequencer.sv - scoreboard bench for tour_cmd_sequencer
// Stimulus pushes expected commands; a negedge monitor pops and compares on each snd_cmd.

module tb_tour_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst, mv_wr, go, cmd_snt, resp_rdy;
  logic [2:0]  mv_in;
  logic [7:0]  resp;
  logic        fifo_full, snd_cmd, busy, done, err;
  logic [15:0] cmd;
  logic [1:0]  err_code;
  logic [4:0]  legs_ok;

  int errors = 0;
  int checks = 0;
  int snd_count = 0;
  int served = 0;
  logic [15:0] exp_q[$];

  logic [15:0] xt [8] = '{16'h4BF1, 16'h4BF2, 16'h4BF2, 16'h4BF1,
                          16'h43F1, 16'h43F2, 16'h43F2, 16'h43F1};
  logic [15:0] yt [8] = '{16'h4002, 16'h4001, 16'h47F1, 16'h47F2,
                          16'h47F2, 16'h47F1, 16'h4001, 16'h4002};

  tour_cmd_sequencer #(.FIFO_DEPTH(8), .RESP_TIMEOUT(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mv_wr_i    (mv_wr),
    .mv_in_i    (mv_in),
    .go_i       (go),
    .fifo_full_o(fifo_full),
    .cmd_o      (cmd),
    .snd_cmd_o  (snd_cmd),
    .cmd_snt_i  (cmd_snt),
    .resp_rdy_i (resp_rdy),
    .resp_i     (resp),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code),
    .legs_ok_o  (legs_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && snd_cmd) begin
      snd_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_snd: got cmd %04h expected no command", cmd);
      end else begin
        check("cmd", cmd, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    mv_wr = 1'b1;
    mv_in = c;
    tick();
    mv_wr = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_snd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (snd_count > served) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) served++;
    else begin
      checks++;
      errors++;
      $display("FAIL snd_timeout: got no snd_cmd expected one within 50 clks");
    end
  endtask

  task automatic serve(input logic [7:0] rb);
    bit ok;
    wait_snd(ok);
    if (!ok) return;
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    tick();
    resp_rdy = 1'b1;
    resp     = rb;
    tick();
    resp_rdy = 1'b0;
    resp     = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b1; mv_wr = 1'b0; mv_in = '0; go = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_full", fifo_full, 0);
    check("rst_legs", legs_ok, 0);

    // 1: single move code 3
    push(3);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1); exp_q.push_back(16'h57F2);
    pulse_go();
    check("t1_busy_run", busy, 1);
    repeat (3) serve(8'hA5);
    check("t1_done", done, 1);
    check("t1_legs", legs_ok, 2);
    check("t1_busy", busy, 0);

    // 2: codes 0,5, re-armed from DONE
    push(0); push(5);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1); exp_q.push_back(16'h4002);
    exp_q.push_back(16'h43F2); exp_q.push_back(16'h57F1);
    pulse_go();
    check("t2_legs_clr", legs_ok, 0);
    check("t2_done_clr", done, 0);
    repeat (5) serve(8'hA5);
    check("t2_done", done, 1);
    check("t2_legs", legs_ok, 4);

    // 3: bad response byte on the X leg
    push(1);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF2);
    pulse_go();
    serve(8'hA5);
    serve(8'h5A);
    check("t3_err", err, 1);
    check("t3_code", err_code, 2'b01);
    check("t3_busy", busy, 0);
    check("t3_legs", legs_ok, 0);
    repeat (10) tick();
    check("t3_no_snd", snd_count, served);

    // 4: response timeout, err exactly 4 clks after cmd_snt sampled
    push(6);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h43F2);
    pulse_go();
    check("t4_err_clr", err, 0);
    check("t4_code_clr", err_code, 0);
    serve(8'hA5);
    wait_snd(ok);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (3) tick();
    check("t4_err_early", err, 0);
    tick();
    check("t4_err", err, 1);
    check("t4_code", err_code, 2'b10);

    // 5: fill FIFO, overflow dropped, push during busy extends tour
    for (int i = 0; i < 7; i++) push(3'(i));
    check("t5_not_full", fifo_full, 0);
    push(7);
    check("t5_full", fifo_full, 1);
    push(3);
    check("t5_still_full", fifo_full, 1);
    exp_q.push_back(16'h2000);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(xt[i]);
      exp_q.push_back(yt[i]);
    end
    exp_q.push_back(16'h4BF2); exp_q.push_back(16'h57F1);
    pulse_go();
    repeat (5) serve(8'hA5);
    push(2);
    repeat (14) serve(8'hA5);
    check("t5_done", done, 1);
    check("t5_legs", legs_ok, 18);

    // 6: reset in WAIT_RESP
    push(4); push(5);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h43F1);
    pulse_go();
    serve(8'hA5);
    wait_snd(ok);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_cmd", cmd, 16'h0000);
    check("t6_legs", legs_ok, 0);
    check("t6_code", err_code, 0);
    resp_rdy = 1'b1; resp = 8'hA5;
    tick();
    resp_rdy = 1'b0;
    check("t6_late_resp", legs_ok, 0);
    pulse_go();
    tick();
    check("t6_go_empty", busy, 0);
    check("t6_no_snd", snd_count, served);
    push(7);
    exp_q.push_back(16'h2000); exp_q.push_back(16'h43F1); exp_q.push_back(16'h5002);
    pulse_go();
    repeat (3) serve(8'hA5);
    check("t6_done", done, 1);
    check("t6_legs2", legs_ok, 2);

    tick();
    check("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
